uart_tx_frame_ctrl: RTL

Transmit-side controller that sits directly upstream of the 12-bit serial shift register in the UART TX path. It accepts a byte from the PicoBlaze port interface, builds a 12-bit frame (start, 8 data bits, parity, 2 stop bits), and drives the shift register's parallel data, load and shift strobes at the baud rate. It reports busy/done status back to the processor.

---
 rtl/uart_tx_frame_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: builds a 12-bit start/data/parity/stop frame and
// drives load/shift strobes for the downstream serial shift register at the baud rate.
module uart_tx_frame_ctrl #(
   parameter int unsigned BAUD_DIV   = 5208,
   parameter bit          PARITY_EN  = 1'b1,
   parameter bit          PARITY_ODD = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        tx_start,
   input  logic [7:0]  tx_data,
   output logic [11:0] frame,
   output logic        load,
   output logic        shift,
   output logic        busy,
   output logic        done,
   output logic        overrun
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_STOP  = 2'd3
   } state_t;

   localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 32'd1);

   // Bit 9 of the frame: parity when enabled, otherwise an extra stop bit.
   function automatic logic parity_bit(input logic [7:0] d);
      logic p;
      if (!PARITY_EN) begin
         p = 1'b1;
      end else if (PARITY_ODD) begin
         p = ~^d;
      end else begin
         p = ^d;
      end
      return p;
   endfunction

   state_t      state_r;
   logic [15:0] baud_cnt_r;
   logic [3:0]  bit_cnt_r;
   logic [11:0] frame_r;
   logic        load_r;
   logic        shift_r;
   logic        busy_r;
   logic        done_r;
   logic        overrun_r;

   logic        accept_s;
   logic        drop_s;
   logic        baud_wrap_s;

   assign accept_s    = cs & tx_start & (state_r == ST_IDLE);
   assign drop_s      = cs & tx_start & (state_r != ST_IDLE);
   assign baud_wrap_s = (baud_cnt_r == BAUD_LAST);

   // Frame sequencer: the first shift leaves LOAD directly, the remaining eleven
   // are paced by the baud counter, and STOP gives the last stop bit a full bit time.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         baud_cnt_r <= 16'd0;
         bit_cnt_r  <= 4'd0;
         frame_r    <= 12'hFFF;
         load_r     <= 1'b0;
         shift_r    <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         overrun_r  <= 1'b0;
      end else begin
         load_r    <= 1'b0;
         shift_r   <= 1'b0;
         done_r    <= 1'b0;
         overrun_r <= drop_s;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  frame_r <= {2'b11, parity_bit(tx_data), tx_data, 1'b0};
                  load_r  <= 1'b1;
                  busy_r  <= 1'b1;
                  state_r <= ST_LOAD;
               end else begin
                  busy_r  <= 1'b0;
               end
            end
            ST_LOAD: begin
               shift_r    <= 1'b1;
               bit_cnt_r  <= 4'd1;
               baud_cnt_r <= 16'd0;
               state_r    <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (baud_wrap_s) begin
                  baud_cnt_r <= 16'd0;
                  shift_r    <= 1'b1;
                  bit_cnt_r  <= bit_cnt_r + 4'd1;
                  if (bit_cnt_r == 4'd11) begin
                     state_r <= ST_STOP;
                  end else begin
                     state_r <= ST_SHIFT;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + 16'd1;
               end
            end
            ST_STOP: begin
               if (baud_wrap_s) begin
                  baud_cnt_r <= 16'd0;
                  bit_cnt_r  <= 4'd0;
                  done_r     <= 1'b1;
                  busy_r     <= 1'b0;
                  state_r    <= ST_IDLE;
               end else begin
                  baud_cnt_r <= baud_cnt_r + 16'd1;
               end
            end
            default: begin
               baud_cnt_r <= 16'd0;
               bit_cnt_r  <= 4'd0;
               busy_r     <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

   assign frame   = frame_r;
   assign load    = load_r;
   assign shift   = shift_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign overrun = overrun_r;

endmodule
